// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and types for the LIF neuron array
package lif_pkg;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_W          = 8;
  localparam int DEF_LEAK_SHIFT = 1;
  localparam int DEF_REFRAC     = 2;
  localparam int SPIKE_CNT_W    = 16;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } ch_state_e;

endpackage

// File: rtl/lif_neuron_array_if.sv
// rtl/lif_neuron_array_if.sv - control, current and observation bundle of the neuron array
interface lif_neuron_array_if #(
  parameter int N_CH = lif_pkg::DEF_N_CH,
  parameter int W    = lif_pkg::DEF_W
);
  logic                          en;
  logic                          leak_en;
  logic [W-1:0]                  threshold;
  logic [N_CH*W-1:0]             current;
  logic [N_CH-1:0]               spike;
  logic [N_CH*W-1:0]             state;
  logic [N_CH-1:0]               refrac;
  logic [lif_pkg::SPIKE_CNT_W-1:0] spike_count;

  modport master (
    output en, leak_en, threshold, current,
    input  spike, state, refrac, spike_count
  );

  modport slave (
    input  en, leak_en, threshold, current,
    output spike, state, refrac, spike_count
  );
endinterface

// File: rtl/lif_channel.sv
// rtl/lif_channel.sv - single leaky integrate-and-fire neuron with refractory counter
module lif_channel
  import lif_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         leak_en_i,
  input  logic [W-1:0] threshold_i,
  input  logic [W-1:0] current_i,
  output logic         spike_o,
  output logic         spike_nx_o,
  output logic [W-1:0] state_o,
  output logic         refrac_o
);

  localparam int CW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [CW-1:0] REFRAC_LD = CW'(REFRAC);

  ch_state_e    st_q, st_d;
  logic [W-1:0] v_q, v_d;
  logic         spike_q, spike_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]   leak, sum;

  always_comb begin
    st_d    = st_q;
    v_d     = v_q;
    spike_d = spike_q;
    cnt_d   = cnt_q;
    leak    = leak_en_i ? {1'b0, v_q >> LEAK_SHIFT} : '0;
    // One extra bit keeps state + current from wrapping before the compare
    sum     = {1'b0, v_q} - leak + {1'b0, current_i};
    if (en_i) begin
      spike_d = 1'b0;
      if (st_q == INTEGRATE) begin
        if (sum >= {1'b0, threshold_i}) begin
          spike_d = 1'b1;
          v_d     = '0;
          if (REFRAC > 0) begin
            st_d  = REFRACTORY;
            cnt_d = REFRAC_LD;
          end
        end else begin
          v_d = sum[W] ? '1 : sum[W-1:0];
        end
      end else begin
        v_d   = '0;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) st_d = INTEGRATE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= INTEGRATE;
      v_q     <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike_o    = spike_q;
  assign spike_nx_o = spike_d;
  assign state_o    = v_q;
  assign refrac_o   = (st_q == REFRACTORY);

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - N_CH independent LIF neurons with a shared saturating spike counter
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int W          = DEF_W,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC
) (
  input logic               clk,
  input logic               rst_n,
  lif_neuron_array_if.slave bus
);

  logic [N_CH-1:0]        spike_nx;
  logic [4:0]             pop;
  logic [SPIKE_CNT_W:0]   cnt_sum;
  logic [SPIKE_CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lif_channel #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (bus.en),
      .leak_en_i   (bus.leak_en),
      .threshold_i (bus.threshold),
      .current_i   (bus.current[i*W +: W]),
      .spike_o     (bus.spike[i]),
      .spike_nx_o  (spike_nx[i]),
      .state_o     (bus.state[i*W +: W]),
      .refrac_o    (bus.refrac[i])
    );
  end

  // Counts the spikes about to be registered, so simultaneous firings all land in one update
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + 5'(spike_nx[i]);
    cnt_sum = {1'b0, cnt_q} + (SPIKE_CNT_W + 1)'(pop);
    cnt_d   = cnt_q;
    if (bus.en) cnt_d = cnt_sum[SPIKE_CNT_W] ? '1 : cnt_sum[SPIKE_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.spike_count = cnt_q;

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent neuron channels, range 1..16.
REQ-002 Parameter W, default 8: membrane state, input current and threshold width.
REQ-003 Parameter LEAK_SHIFT, default 1: leak amount per update is state >> LEAK_SHIFT.
REQ-004 Parameter REFRAC, default 2: refractory cycles after a spike; 0 disables refractory.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  update enable; low freezes every register.
REQ-008 leak_en  in  1  high applies leak; low gives pure integrate-and-fire.
REQ-009 threshold  in  W  firing threshold shared by all channels, unsigned.
REQ-010 current  in  N_CH*W  per-channel input current, channel i at [i*W +: W], unsigned.
REQ-011 spike  out  N_CH  registered one-cycle spike pulse per channel.
REQ-012 state  out  N_CH*W  registered membrane state per channel, same packing as current.
REQ-013 refrac  out  N_CH  high while the channel is in refractory.
REQ-014 spike_count  out  16  saturating total of all spikes since reset.

Function
REQ-015 Each channel has two states, INTEGRATE and REFRACTORY, with a refractory down-counter of width clog2(REFRAC+1).
REQ-016 In INTEGRATE with en=1: sum = state - (leak_en ? state>>LEAK_SHIFT : 0) + current, computed W+1 bits wide, no wrap.
REQ-017 If sum >= threshold: spike=1 next cycle, state=0, and the channel enters REFRACTORY with counter=REFRAC (stays INTEGRATE if REFRAC=0).
REQ-018 Otherwise: state = min(sum, 2^W-1), spike=0.
REQ-019 In REFRACTORY with en=1: state held at 0, current ignored, spike=0, counter decrements; at counter 1 -> INTEGRATE, so exactly REFRAC cycles are skipped.
REQ-020 refrac output = (channel state == REFRACTORY), registered.
REQ-021 Latency: current sampled at edge t appears in state/spike at edge t; spike is high for exactly one cycle per firing.
REQ-022 threshold=0: every INTEGRATE cycle fires, including current=0.
REQ-023 en=0: state, spike, refrac, counters and spike_count all hold; a spike pulse present when en falls stays asserted until en returns.
REQ-024 spike_count adds popcount(next spike vector) each enabled cycle, saturating at 0xFFFF; simultaneous spikes all counted.
REQ-025 Channels are fully independent except for shared threshold, en, leak_en and spike_count.

Reset
REQ-026 rst_n=0 at a rising edge: state=0, spike=0, refrac=0, counters=0, all channels INTEGRATE, spike_count=0, regardless of en.
REQ-027 Reset asserted mid-refractory or during a spike cycle aborts it; the first post-reset edge with en=1 integrates normally.

Structure
REQ-028 A shared package lif_pkg holds default parameter constants, the channel-state enumeration (INTEGRATE, REFRACTORY) and the spike-counter width (16).
REQ-029 One sub-module, lif_channel, implements a single neuron (REQ-015..020); lif_neuron_array instantiates N_CH of them and owns spike_count.

Verification
REQ-030 W=8, threshold=0xE6, leak_en=1, ch0 current=100 held -> state 100,150,175,188,194,197,199,200,200; no spike ever.
REQ-031 leak_en=0, ch0 current=100, REFRAC=2 -> state 100,200, then spike=1 with state 0, refrac high 2 cycles (state 0), then 100,200, spike again; spike_count increments once per firing.
REQ-032 Saturation: leak_en=0, threshold=0xFF, current=0xF0 -> state 0xF0, then sum 0x1E0>=0xFF fires; with threshold forced above range never reachable (threshold=0xFF, current=0x7F) -> state 0x7F, then 0xFE, then 0x17D fires, not wrap.
REQ-033 All 4 channels current=0xFF, threshold=0x10 same cycle -> spike=4'b1111 and spike_count +4; preload spike_count to 0xFFFE via repeated firing -> saturates at 0xFFFF.
REQ-034 en dropped for 3 cycles mid-refractory -> all outputs frozen, remaining refractory cycles resume after en=1.
REQ-035 rst_n low during REFRACTORY with state nonzero on another channel -> all outputs 0 next edge; next enabled edge integrates current.
